tester_gtx_chk: RTL and testbench
=================================

TESTER_GTX_CHK -- requirements
Module: tester_gtx_chk

Interface
REQ-001 Parameter IDLE, default 16'h02bc, is the idle K-word expected on rxdata when rxchar is 2'b01.
REQ-002 Parameter LOSS_THR, default 8, is the number of consecutive bad words that drops lock.
REQ-003 usrclk  input  1  receive user clock; the block has one clock, and all logic is on its rising edge.
REQ-004 usrrst  input  1  reset, synchronous to usrclk and active-high.
REQ-005 rxdata  input  16  received word from the GTX receiver.
REQ-006 rxchar  input  2  per-byte K-char flags from the GTX receiver.
REQ-007 chk_clr  input  1  synchronous clear of the statistics counters.
REQ-008 chk_lock  output  1  high while the checker is synchronised to the stream.
REQ-009 err_pulse  output  1  one-cycle flag for each detected error.
REQ-010 err_cnt  output  32  saturating error count.
REQ-011 burst_cnt  output  32  saturating count of completed data bursts.

Function
REQ-012 Each input word shall be classified as follows: IDLE_W when rxchar==2'b01 and rxdata==IDLE; DATA_W when rxchar==2'b00; BAD_W for anything else.
REQ-013 Inputs shall be registered once, and all outputs shall update on the edge after that register stage, giving a latency of 2 usrclk cycles from an input word to its flags.
REQ-014 The state machine shall have three states: HUNT, GAP and BURST; HUNT is the reset state.
REQ-015 HUNT: on 4 consecutive IDLE_W the FSM shall go to GAP and set chk_lock=1; any other word shall restart the run count; no errors shall be counted in HUNT.
REQ-016 GAP + IDLE_W: the FSM shall stay in GAP.
REQ-017 GAP + DATA_W: the FSM shall go to BURST; on the first burst after HUNT, expected shall be seeded to rxdata+1 with no error flagged; on later bursts the word shall be compared to expected.
REQ-018 BURST + DATA_W: the word shall be compared to expected; on a mismatch, err_pulse shall assert and expected shall be reloaded to rxdata+1 (resync); on a match, expected shall become expected+1.
REQ-019 BURST + IDLE_W: the FSM shall go to GAP and burst_cnt shall increment.
REQ-020 BAD_W in GAP or BURST: err_pulse shall assert, the state shall be unchanged, and expected shall be unchanged.
REQ-021 Expected-value arithmetic shall be 16-bit modulo, so 16'hFFFF is followed by 16'h0000 with no error.
REQ-022 Data continuity shall be checked across bursts: the first word of burst N+1 shall equal the last word of burst N plus 1.
REQ-023 A LOSS_THR-run counter shall count consecutive erroneous words in GAP or BURST and reset on any good word; when it reaches LOSS_THR, the FSM shall go to HUNT, chk_lock shall go to 0, and the seed flag shall be cleared.
REQ-024 err_cnt shall increment by exactly 1 per cycle in which err_pulse=1.
REQ-025 err_cnt and burst_cnt shall saturate at 32'hFFFFFFFF.
REQ-026 chk_clr shall zero err_cnt and burst_cnt and take priority over a simultaneous increment; it shall not affect the FSM, chk_lock or expected.

Reset
REQ-027 On usrrst=1 at a clock edge: the state shall be HUNT, chk_lock=0, err_pulse=0, err_cnt=0, burst_cnt=0, expected=16'h0000, and all run counters and the seed flag shall be cleared.
REQ-028 Reset asserted mid-burst shall discard the burst, and the checker shall re-hunt from the next cycle after reset is released.

Configuration
REQ-029 With TESTER_GTX_CHK_BLEN_EN defined, the block shall count the DATA_W words in each burst and, on the BURST to GAP transition, shall assert err_pulse on that cycle if the count is not 32; this is the burst-length error.
REQ-030 A burst-length error shall increment err_cnt by 1 in total when it coincides with no other error in the same cycle.
REQ-031 Without TESTER_GTX_CHK_BLEN_EN, burst length shall be unchecked, and no length counter shall be synthesised.

Structure
REQ-032 The IDLE default, the K-flag encodings (2'b00 and 2'b01), the burst length constant 32 and the state encodings shall live in the shared package tester_gtx_pkg.
REQ-033 The saturating counter with clear shall be the sub-module tester_gtx_satcnt, instantiated twice, once for err_cnt and once for burst_cnt.

Verification
REQ-034 The bench shall cover these directed scenarios:
- Scenario 1: 4 idle words, then bursts of 32 incrementing words (0..31, 32..63) with 5-word idle gaps. Required: chk_lock=1, err_cnt=0, burst_cnt=2.
- Scenario 2: while locked, the word 16'h0010 in a burst is replaced with 16'h1234. Required: exactly one err_pulse, err_cnt=1, and the following word 16'h1235 is accepted (resync).
- Scenario 3: a burst spans 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001. Required: no error.
- Scenario 4: 8 consecutive words with rxchar=2'b11. Required: err_cnt=8 and chk_lock drops to 0 on the 8th error. Then 4 idle words followed by data. Required: relock, with the first word seeded and no error.
- Scenario 5 (TESTER_GTX_CHK_BLEN_EN defined): a burst of 31 words. Required: one err_pulse on the idle word that ends it. Macro undefined: no error.
- Scenario 6: chk_clr asserted in the same cycle as err_pulse. Required: err_cnt reads 0 the next cycle. Separately, usrrst asserted mid-burst. Required: all outputs return to their reset values.

Source files
------------

// File: rtl/tester_gtx_pkg.sv
// Shared constants, state encodings and word classifier for the GTX stream checker.
package tester_gtx_pkg;

  localparam logic [15:0] IDLE_DEF  = 16'h02bc;
  localparam logic [1:0]  KFLG_DATA = 2'b00;
  localparam logic [1:0]  KFLG_IDLE = 2'b01;
  localparam int          BURST_LEN = 32;
  localparam int          HUNT_RUN  = 4;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_GAP   = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WC_IDLE = 2'd0,
    WC_DATA = 2'd1,
    WC_BAD  = 2'd2
  } wclass_e;

  function automatic wclass_e classify(input logic [15:0] data,
                                       input logic [1:0]  kflg,
                                       input logic [15:0] idle);
    if (kflg == KFLG_IDLE && data == idle) return WC_IDLE;
    if (kflg == KFLG_DATA) return WC_DATA;
    return WC_BAD;
  endfunction

endpackage

// File: rtl/tester_gtx_satcnt.sv
// 32-bit saturating event counter with synchronous clear (clear beats increment).
module tester_gtx_satcnt (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      r_cnt <= '0;
    else if (i_inc && r_cnt != 32'hFFFF_FFFF)
      r_cnt <= r_cnt + 32'd1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/tester_gtx_chk.sv
// GTX receive-stream checker: idle-hunt lock, incrementing-data continuity, loss of lock.
// Optional burst-length check enabled by defining TESTER_GTX_CHK_BLEN_EN.
module tester_gtx_chk
  import tester_gtx_pkg::*;
#(
  parameter logic [15:0] IDLE     = IDLE_DEF,
  parameter int          LOSS_THR = 8
) (
  input  logic        usrclk,
  input  logic        usrrst,
  input  logic [15:0] rxdata,
  input  logic [1:0]  rxchar,
  input  logic        chk_clr,
  output logic        chk_lock,
  output logic        err_pulse,
  output logic [31:0] err_cnt,
  output logic [31:0] burst_cnt
);

  localparam int LW = $clog2(LOSS_THR + 1);

  logic [15:0]   r_rxdata_p1;
  logic [1:0]    r_rxchar_p1;
  logic          r_vld_p1;
  state_e        r_state, w_state_nxt;
  logic [2:0]    r_run, w_run_nxt;
  logic [LW-1:0] r_loss, w_loss_nxt;
  logic          r_seeded, w_seeded_nxt;
  logic [15:0]   r_exp, w_exp_nxt;
  logic          r_err_p2;
  wclass_e       w_class;
  logic          w_mismatch, w_err, w_bdone, w_loss_hit;
`ifdef TESTER_GTX_CHK_BLEN_EN
  localparam int BLW = $clog2(BURST_LEN) + 1;
  logic [BLW-1:0] r_blen, w_blen_nxt;
`endif

  // Stage p1: input capture
  always_ff @(posedge usrclk) begin
    r_rxdata_p1 <= rxdata;
    r_rxchar_p1 <= rxchar;
  end

  always_ff @(posedge usrclk) begin
    if (usrrst) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= 1'b1;
  end

  assign w_class    = classify(r_rxdata_p1, r_rxchar_p1, IDLE);
  assign w_mismatch = r_seeded && (r_rxdata_p1 != r_exp);
  assign w_loss_hit = w_err && (r_loss == LW'(LOSS_THR - 1));

  // Output decode: error and burst-complete flags for the word in p1
  always_comb begin
    w_err   = 1'b0;
    w_bdone = 1'b0;
    if (r_vld_p1 && r_state != ST_HUNT) begin
      unique case (w_class)
        WC_BAD:  w_err = 1'b1;
        WC_DATA: w_err = w_mismatch;
        WC_IDLE: begin
          if (r_state == ST_BURST) begin
            w_bdone = 1'b1;
`ifdef TESTER_GTX_CHK_BLEN_EN
            w_err = (r_blen != BLW'(BURST_LEN));
`endif
          end
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  // Next-state: a matched word gives exp+1 == rxdata+1, so every data word reloads rxdata+1
  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_loss_nxt   = r_loss;
    w_seeded_nxt = r_seeded;
    w_exp_nxt    = r_exp;
`ifdef TESTER_GTX_CHK_BLEN_EN
    w_blen_nxt   = r_blen;
`endif
    if (r_vld_p1) begin
      if (r_state == ST_HUNT) begin
        if (w_class == WC_IDLE && r_run == 3'(HUNT_RUN - 1)) begin
          w_state_nxt = ST_GAP;
          w_run_nxt   = '0;
        end else if (w_class == WC_IDLE) begin
          w_run_nxt = r_run + 3'd1;
        end else begin
          w_run_nxt = '0;
        end
        w_loss_nxt = '0;
      end else begin
        w_run_nxt  = '0;
        w_loss_nxt = w_err ? r_loss + LW'(1) : '0;
        if (w_class == WC_DATA) begin
          w_exp_nxt    = r_rxdata_p1 + 16'd1;
          w_seeded_nxt = 1'b1;
          if (r_state == ST_GAP) w_state_nxt = ST_BURST;
`ifdef TESTER_GTX_CHK_BLEN_EN
          if (r_state == ST_GAP)   w_blen_nxt = BLW'(1);
          else if (r_blen != '1)   w_blen_nxt = r_blen + BLW'(1);
`endif
        end else if (w_class == WC_IDLE) begin
          w_state_nxt = ST_GAP;
        end
        if (w_loss_hit) begin
          w_state_nxt  = ST_HUNT;
          w_loss_nxt   = '0;
          w_seeded_nxt = 1'b0;
        end
      end
    end
  end

  // Stage p2: state and flag registers
  always_ff @(posedge usrclk) begin
    if (usrrst) begin
      r_state  <= ST_HUNT;
      r_run    <= '0;
      r_loss   <= '0;
      r_seeded <= 1'b0;
      r_exp    <= 16'h0000;
      r_err_p2 <= 1'b0;
`ifdef TESTER_GTX_CHK_BLEN_EN
      r_blen   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_loss   <= w_loss_nxt;
      r_seeded <= w_seeded_nxt;
      r_exp    <= w_exp_nxt;
      r_err_p2 <= w_err;
`ifdef TESTER_GTX_CHK_BLEN_EN
      r_blen   <= w_blen_nxt;
`endif
    end
  end

  tester_gtx_satcnt u_err_cnt (
    .i_clk (usrclk),
    .i_rst (usrrst),
    .i_clr (chk_clr),
    .i_inc (w_err),
    .o_cnt (err_cnt)
  );

  tester_gtx_satcnt u_burst_cnt (
    .i_clk (usrclk),
    .i_rst (usrrst),
    .i_clr (chk_clr),
    .i_inc (w_bdone),
    .o_cnt (burst_cnt)
  );

  assign chk_lock  = (r_state != ST_HUNT);
  assign err_pulse = r_err_p2;

endmodule

// File: tb/tb_tester_gtx_chk.sv
// Bench for tester_gtx_chk: directed scenarios plus a randomized stream against a word-level model.
module tb_tester_gtx_chk;

  localparam logic [15:0] B_IDLE = 16'h02bc;
  localparam int          B_LOSS = 8;
  localparam int          B_BLEN = 32;

  logic        usrclk = 1'b0;
  logic        usrrst, chk_clr;
  logic [15:0] rxdata;
  logic [1:0]  rxchar;
  logic        chk_lock, err_pulse;
  logic [31:0] err_cnt, burst_cnt;

  always #5 usrclk = ~usrclk;

  tester_gtx_chk dut (
    .usrclk    (usrclk),
    .usrrst    (usrrst),
    .rxdata    (rxdata),
    .rxchar    (rxchar),
    .chk_clr   (chk_clr),
    .chk_lock  (chk_lock),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .burst_cnt (burst_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  // Word-level reference model
  bit          m_locked, m_inburst, m_seeded, m_pv, m_err, m_done;
  logic [15:0] m_exp, m_pd;
  logic [1:0]  m_pc;
  int          m_run, m_loss, m_blen;
  logic [31:0] m_ec, m_bc;

  logic [15:0] cur;
  int          n_idle, seg_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_word(input logic [15:0] d, input logic [1:0] c);
    bit is_idle, is_data, bad;
    is_idle = (c == 2'b01) && (d == B_IDLE);
    is_data = (c == 2'b00);
    bad = 0;
    if (!m_locked) begin
      if (is_idle) begin
        m_run++;
        if (m_run == 4) begin
          m_locked = 1; m_inburst = 0; m_run = 0; m_loss = 0;
        end
      end else m_run = 0;
      return;
    end
    if (is_data) begin
      if (!m_inburst) begin m_inburst = 1; m_blen = 1; end
      else m_blen++;
      if (!m_seeded) begin m_seeded = 1; m_exp = d + 16'd1; end
      else if (d != m_exp) begin bad = 1; m_exp = d + 16'd1; end
      else m_exp = m_exp + 16'd1;
    end else if (is_idle) begin
      if (m_inburst) begin
        m_inburst = 0; m_done = 1;
`ifdef TESTER_GTX_CHK_BLEN_EN
        if (m_blen != B_BLEN) bad = 1;
`endif
      end
    end else bad = 1;
    if (bad) begin
      m_err = 1;
      m_loss++;
      if (m_loss == B_LOSS) begin
        m_locked = 0; m_seeded = 0; m_loss = 0; m_run = 0; m_inburst = 0;
      end
    end else m_loss = 0;
  endtask

  task automatic model_edge(input logic [15:0] d, input logic [1:0] c, input bit clr, input bit rst);
    m_err = 0; m_done = 0;
    if (rst) begin
      m_locked = 0; m_inburst = 0; m_seeded = 0; m_pv = 0;
      m_exp = 16'h0000; m_run = 0; m_loss = 0; m_blen = 0;
      m_ec = 0; m_bc = 0;
      return;
    end
    if (m_pv) model_word(m_pd, m_pc);
    if (clr) begin
      m_ec = 0; m_bc = 0;
    end else begin
      if (m_err  && m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 1;
      if (m_done && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
    end
    m_pd = d; m_pc = c; m_pv = 1;
  endtask

  task automatic tick(input logic [15:0] d, input logic [1:0] c, input bit clr, input bit rst);
    rxdata = d; rxchar = c; chk_clr = clr; usrrst = rst;
    @(posedge usrclk); #1;
    model_edge(d, c, clr, rst);
    if (err_pulse === 1'b1) pulses++;
    check("chk_lock",  {31'd0, chk_lock},  {31'd0, m_locked});
    check("err_pulse", {31'd0, err_pulse}, {31'd0, m_err});
    check("err_cnt",   err_cnt,   m_ec);
    check("burst_cnt", burst_cnt, m_bc);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) tick(B_IDLE, 2'b01, 0, 0);
  endtask

  task automatic burst(input logic [15:0] start, input int len);
    for (int i = 0; i < len; i++) tick(start + 16'(i), 2'b00, 0, 0);
  endtask

  task automatic bad_word();
    tick(16'h00AA, 2'b11, 0, 0);
  endtask

  initial begin
    usrrst = 1; chk_clr = 0; rxdata = 16'h0; rxchar = 2'b00;
    tick(B_IDLE, 2'b01, 0, 1);
    tick(B_IDLE, 2'b01, 0, 1);
    check("rst_lock",  {31'd0, chk_lock},  32'd0);
    check("rst_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_errc",  err_cnt,   32'd0);
    check("rst_bc",    burst_cnt, 32'd0);

    // Scenario 1: lock and two clean bursts
    idles(4); burst(16'd0, 32); idles(5); burst(16'd32, 32); idles(5);
    check("s1_lock",  {31'd0, chk_lock}, 32'd1);
    check("s1_errc",  err_cnt,   32'd0);
    check("s1_bc",    burst_cnt, 32'd2);

    // Scenario 2: one corrupted word followed by resync
    tick(B_IDLE, 2'b01, 0, 1);
    idles(4); pulses = 0;
    burst(16'd0, 16); burst(16'h1234, 16); idles(3);
    check("s2_pulses", pulses,  32'd1);
    check("s2_errc",   err_cnt, 32'd1);

    // Scenario 3: modulo wrap inside a burst
    tick(B_IDLE, 2'b01, 0, 1);
    idles(4); pulses = 0;
    burst(16'hFFF0, 32); idles(3);
    check("s3_pulses", pulses,    32'd0);
    check("s3_bc",     burst_cnt, 32'd1);

    // Scenario 4: loss of lock after eight bad words, then relock
    tick(B_IDLE, 2'b01, 1, 0);
    for (int i = 0; i < 8; i++) bad_word();
    check("s4_lock7", {31'd0, chk_lock}, 32'd1);
    idles(1);
    check("s4_pulse8", {31'd0, err_pulse}, 32'd1);
    check("s4_lock8",  {31'd0, chk_lock},  32'd0);
    check("s4_errc",   err_cnt, 32'd8);
    idles(4); pulses = 0;
    burst(16'h4000, 32); idles(3);
    check("s4_relock", {31'd0, chk_lock}, 32'd1);
    check("s4_pulses", pulses, 32'd0);

    // Scenario 5: short burst of 31 words
    pulses = 0;
    burst(16'h4020, 31); idles(3);
`ifdef TESTER_GTX_CHK_BLEN_EN
    check("s5_pulses", pulses,  32'd1);
    check("s5_errc",   err_cnt, 32'd9);
`else
    check("s5_pulses", pulses,  32'd0);
    check("s5_errc",   err_cnt, 32'd8);
`endif

    // Scenario 6: clear coincident with err_pulse, then reset mid-burst
    bad_word(); bad_word();
    check("s6_pulse", {31'd0, err_pulse}, 32'd1);
    tick(B_IDLE, 2'b01, 1, 0);
    check("s6_clr", err_cnt, 32'd0);
    idles(2); burst(16'h5000, 10);
    tick(16'h500A, 2'b00, 0, 1);
    check("s6_rlock",  {31'd0, chk_lock},  32'd0);
    check("s6_rpulse", {31'd0, err_pulse}, 32'd0);
    check("s6_rerrc",  err_cnt,   32'd0);
    check("s6_rbc",    burst_cnt, 32'd0);
    burst(16'h500B, 3);
    check("s6_hunt", {31'd0, chk_lock}, 32'd0);
    idles(4); burst(16'h6000, 32); idles(2);
    check("s6_relock", {31'd0, chk_lock}, 32'd1);

    // Randomized stream
    cur = 16'($urandom);
    for (int s = 0; s < 60; s++) begin
      n_idle = $urandom_range(1, 6);
      for (int k = 0; k < n_idle; k++)
        tick(B_IDLE, 2'b01, ($urandom_range(0, 99) < 3), 0);
      if ($urandom_range(0, 9) == 0) cur = 16'($urandom);
      seg_len = ($urandom_range(0, 9) < 7) ? 32 : $urandom_range(28, 34);
      for (int i = 0; i < seg_len; i++) begin
        if ($urandom_range(0, 99) < 4) begin
          if ($urandom_range(0, 1) == 0) tick(B_IDLE ^ 16'h0001, 2'b01, 0, 0);
          else tick(16'($urandom), 2'($urandom_range(2, 3)), 0, 0);
        end else if ($urandom_range(0, 99) < 2) begin
          tick(16'($urandom), 2'b00, 0, 0);
        end else begin
          tick(cur, 2'b00, ($urandom_range(0, 99) < 2), 0);
          cur = cur + 16'd1;
        end
      end
      if ($urandom_range(0, 14) == 0)
        for (int k = 0; k < 9; k++) bad_word();
      if ($urandom_range(0, 29) == 0)
        tick(B_IDLE, 2'b01, 0, 1);
    end
    idles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
